// File: rtl/clk_div_pkg.sv
// clk_div_pkg: master clock rate, counter width and half-period helpers for the divider bank
package clk_div_pkg;
  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int CNT_W = 27;
  function automatic logic [CNT_W-1:0] half_period(input int unsigned freq_hz);
    return CNT_W'(CLK_HZ / (2 * freq_hz));
  endfunction
  localparam logic [CNT_W-1:0] HP_1HZ = half_period(1);
  localparam logic [CNT_W-1:0] HP_2HZ = half_period(2);
  localparam logic [CNT_W-1:0] HP_5HZ = half_period(5);
  localparam logic [CNT_W-1:0] HP_500HZ = half_period(500);
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed half-period reload and phase clear.
// Tick flops exist only when CLK_DIV_TICK_EN is defined; otherwise tick_o is tied low.
module clk_div_chan #(
  parameter int CNT_W = 27,
  parameter logic [CNT_W-1:0] DEF = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             clk_o,
  output logic             tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic clk_q, clk_d, off, wrap;
  // a new half-period only takes effect at a wrap, so a running half is never cut short
  always_comb begin
    shd_d = we_i ? half_i : shd_q;
    off = act_q == '0;
    wrap = !clr_i && !off && en_i && cnt_q == act_q - CNT_W'(1);
    cnt_d = (clr_i || off || wrap) ? '0 : en_i ? cnt_q + CNT_W'(1) : cnt_q;
    clk_d = (clr_i || off) ? 1'b0 : clk_q ^ wrap;
    act_d = (clr_i || off) ? shd_d : wrap ? shd_q : act_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      act_q <= DEF;
      shd_q <= DEF;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      shd_q <= shd_d;
      clk_q <= clk_d;
    end
  end
  assign clk_o = clk_q;
`ifdef CLK_DIV_TICK_EN
  logic tick_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else tick_q <= wrap & ~clk_q;
  end
  assign tick_o = tick_q;
`else
  assign tick_o = 1'b0;
`endif
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH programmable 50%-duty divided clocks with per-period ticks.
// Define CLK_DIV_TICK_EN to generate tick_o; otherwise tick_o is tied low.
module clk_div_bank import clk_div_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = clk_div_pkg::CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {HP_500HZ, HP_5HZ, HP_2HZ, HP_1HZ},
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W(CNT_W),
      .DEF  (DEF_HALF[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en),
      .clr_i (sync_clr),
      .we_i  (cfg_we && cfg_ch == CH_W'(i)),
      .half_i(cfg_half),
      .clk_o (clk_o[i]),
      .tick_o(tick_o[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: scoreboard bench for clk_div_bank with a 4-channel, 8-bit configuration
module tb_clk_div_bank;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [N*W-1:0] DEF = {8'd1, 8'd2, 8'd3, 8'd4};
`ifdef CLK_DIV_TICK_EN
  localparam bit TK = 1'b1;
`else
  localparam bit TK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, sync_clr = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [W-1:0] cfg_half = '0;
  logic [N-1:0] clk_o, tick_o;
  int checks = 0, failures = 0;
  logic [2*N-1:0] sb[$];
  logic [2*N-1:0] exp_v;
  logic [W-1:0] m_cnt[N], m_act[N], m_shd[N], m_ns;
  logic m_clk[N], m_tick[N], m_nw;
  logic [N-1:0] m_vc, m_vt;

  always #5 clk = ~clk;

  clk_div_bank #(.NUM_CH(N), .CNT_W(W), .DEF_HALF(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .clk_o(clk_o), .tick_o(tick_o)
  );

  // reference model: one expected {tick,clk} vector pushed per clock edge out of reset
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = '0; m_act[i] = DEF[i*W +: W]; m_shd[i] = DEF[i*W +: W];
        m_clk[i] = 1'b0; m_tick[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_nw = cfg_we && cfg_ch == 2'(i);
        m_ns = m_nw ? cfg_half : m_shd[i];
        if (sync_clr) begin
          m_cnt[i] = '0; m_clk[i] = 1'b0; m_tick[i] = 1'b0; m_act[i] = m_ns;
        end else if (m_act[i] == 0) begin
          m_cnt[i] = '0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
          if (m_nw) m_act[i] = cfg_half;
        end else if (!en) begin
          m_tick[i] = 1'b0;
        end else if (m_cnt[i] == m_act[i] - 8'd1) begin
          m_cnt[i] = '0; m_tick[i] = !m_clk[i]; m_clk[i] = !m_clk[i]; m_act[i] = m_shd[i];
        end else begin
          m_cnt[i] = m_cnt[i] + 8'd1; m_tick[i] = 1'b0;
        end
        m_shd[i] = m_ns;
        m_vc[i] = m_clk[i];
        m_vt[i] = TK & m_tick[i];
      end
      sb.push_back({m_vt, m_vc});
    end
  end

  task automatic test_reset;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (clk_o !== '0 || tick_o !== '0) begin failures++; $display("FAIL reset_hold: clk_o=%b tick_o=%b want 0", clk_o, tick_o); end
    end
    rst = 1'b0;
    sb.delete();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL reset_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v) begin failures++; $display("FAIL reset_sb: cyc=%0d got=%b exp=%b", k, {tick_o, clk_o}, exp_v); end
      end
      checks++;
      if ({tick_o[0], clk_o[0], clk_o[3]} !== {TK && (k == 4 || k == 12), (k / 4) % 2 == 1, k % 2 == 1}) begin
        failures++; $display("FAIL reset_wave: cyc=%0d tick0,clk0,clk3 got=%b", k, {tick_o[0], clk_o[0], clk_o[3]});
      end
    end
  endtask

  task automatic test_reload;
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd9;
    @(negedge clk);
    cfg_half = 8'd2;
    @(negedge clk);
    cfg_we = 1'b0;
    sb.delete();
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL reload_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v) begin failures++; $display("FAIL reload_sb: cyc=%0d got=%b exp=%b", j, {tick_o, clk_o}, exp_v); end
      end
      checks++;
      if (clk_o[0] !== (j >= 2 && (j / 2) % 2 == 1)) begin failures++; $display("FAIL reload_wave: cyc=%0d clk0=%b", j, clk_o[0]); end
    end
  endtask

  task automatic test_offon;
    sync_clr = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd0;
    @(negedge clk);
    sync_clr = 1'b0; cfg_we = 1'b0;
    checks++;
    if (clk_o !== '0) begin failures++; $display("FAIL off_next: clk_o=%b want 0", clk_o); end
    sb.delete();
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL off_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v || clk_o[1] !== 1'b0) begin failures++; $display("FAIL off_sb: cyc=%0d got=%b exp=%b", j, {tick_o, clk_o}, exp_v); end
      end
    end
    cfg_we = 1'b1; cfg_half = 8'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    sb.delete();
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL on_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v) begin failures++; $display("FAIL on_sb: cyc=%0d got=%b exp=%b", j, {tick_o, clk_o}, exp_v); end
      end
      checks++;
      if (clk_o[1] !== (j >= 3 && j <= 5)) begin failures++; $display("FAIL on_wave: cyc=%0d clk1=%b", j, clk_o[1]); end
    end
  endtask

  task automatic test_en;
    sync_clr = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4;
    @(negedge clk);
    sync_clr = 1'b0; cfg_we = 1'b0;
    sb.delete();
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL en_pre_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v) begin failures++; $display("FAIL en_pre_sb: cyc=%0d got=%b exp=%b", j, {tick_o, clk_o}, exp_v); end
      end
    end
    en = 1'b0;
    sb.delete();
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL en_low_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v || clk_o !== 4'b0100 || tick_o !== '0) begin
          failures++; $display("FAIL en_low: cyc=%0d got=%b exp=%b", j, {tick_o, clk_o}, exp_v);
        end
      end
    end
    en = 1'b1;
    sb.delete();
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL en_resume_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v || clk_o[0] !== (j >= 2)) begin
          failures++; $display("FAIL en_resume: cyc=%0d got=%b exp=%b", j, {tick_o, clk_o}, exp_v);
        end
      end
    end
  endtask

  task automatic test_sync_clr;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2;
    @(negedge clk);
    cfg_ch = 2'd1;
    @(negedge clk);
    cfg_we = 1'b0; sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    checks++;
    if (clk_o !== '0 || tick_o !== '0) begin failures++; $display("FAIL clr_next: clk_o=%b tick_o=%b want 0", clk_o, tick_o); end
    sb.delete();
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL clr_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v) begin failures++; $display("FAIL clr_sb: cyc=%0d got=%b exp=%b", j, {tick_o, clk_o}, exp_v); end
      end
      checks++;
      if (clk_o[1:0] !== {2{(j / 2) % 2 == 1}}) begin failures++; $display("FAIL clr_align: cyc=%0d clk1:0=%b", j, clk_o[1:0]); end
    end
  endtask

  task automatic test_rst_async;
    checks++;
    if (clk_o[1:0] !== 2'b11) begin failures++; $display("FAIL rst_pre: clk1:0=%b want 11", clk_o[1:0]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (clk_o !== '0 || tick_o !== '0) begin failures++; $display("FAIL rst_async: clk_o=%b tick_o=%b want 0", clk_o, tick_o); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL rst_sb: queue empty"); end
      else begin
        exp_v = sb.pop_front();
        if ({tick_o, clk_o} !== exp_v) begin failures++; $display("FAIL rst_sb: cyc=%0d got=%b exp=%b", k, {tick_o, clk_o}, exp_v); end
      end
      checks++;
      if ({tick_o[0], clk_o[0], clk_o[3]} !== {TK && k == 4, k >= 4, k % 2 == 1}) begin
        failures++; $display("FAIL rst_def: cyc=%0d tick0,clk0,clk3 got=%b", k, {tick_o[0], clk_o[0], clk_o[3]});
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reload();
    test_offon();
    test_en();
    test_sync_clr();
    test_rst_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
